// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the multi-tap keypad encoder.
//   key_code_t : decoded key function
//   state_t    : scan/debounce FSM states
//   group_base / group_size : ASCII base letter and tap-group length per letter key
//   onehot_idx / decode_key : (row, col) -> key function
package keypad_pkg;

  typedef enum logic [3:0] {
    KEY_ABC,
    KEY_DEF,
    KEY_GHI,
    KEY_JKL,
    KEY_MNO,
    KEY_PQRS,
    KEY_TUV,
    KEY_WXYZ,
    KEY_SUBMIT_LETTER,
    KEY_CLEAR,
    KEY_SUBMIT_WORD,
    KEY_NONE
  } key_code_t;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_HOLD
  } state_t;

  localparam logic [7:0] BASE_ABC  = 8'h41;
  localparam logic [7:0] BASE_DEF  = 8'h44;
  localparam logic [7:0] BASE_GHI  = 8'h47;
  localparam logic [7:0] BASE_JKL  = 8'h4A;
  localparam logic [7:0] BASE_MNO  = 8'h4D;
  localparam logic [7:0] BASE_PQRS = 8'h50;
  localparam logic [7:0] BASE_TUV  = 8'h54;
  localparam logic [7:0] BASE_WXYZ = 8'h57;

  localparam logic [2:0] GROUP_SIZE_3 = 3'd3;
  localparam logic [2:0] GROUP_SIZE_4 = 3'd4;

  function automatic logic is_letter(key_code_t k);
    return k inside {KEY_ABC, KEY_DEF, KEY_GHI, KEY_JKL,
                     KEY_MNO, KEY_PQRS, KEY_TUV, KEY_WXYZ};
  endfunction

  function automatic logic [7:0] group_base(key_code_t k);
    case (k)
      KEY_ABC:  return BASE_ABC;
      KEY_DEF:  return BASE_DEF;
      KEY_GHI:  return BASE_GHI;
      KEY_JKL:  return BASE_JKL;
      KEY_MNO:  return BASE_MNO;
      KEY_PQRS: return BASE_PQRS;
      KEY_TUV:  return BASE_TUV;
      KEY_WXYZ: return BASE_WXYZ;
      default:  return 8'h00;
    endcase
  endfunction

  function automatic logic [2:0] group_size(key_code_t k);
    if (k == KEY_PQRS || k == KEY_WXYZ) return GROUP_SIZE_4;
    return GROUP_SIZE_3;
  endfunction

  // Index of the set bit in a one-hot nibble (0 when bit 0 or nothing is set).
  function automatic logic [1:0] onehot_idx(logic [3:0] v);
    if (v[3]) return 2'd3;
    if (v[2]) return 2'd2;
    if (v[1]) return 2'd1;
    return 2'd0;
  endfunction

  function automatic key_code_t decode_key(logic [1:0] row, logic [1:0] col);
    case ({row, col})
      4'b00_01: return KEY_ABC;
      4'b00_10: return KEY_DEF;
      4'b01_00: return KEY_GHI;
      4'b01_01: return KEY_JKL;
      4'b01_10: return KEY_MNO;
      4'b10_00: return KEY_PQRS;
      4'b10_01: return KEY_TUV;
      4'b10_10: return KEY_WXYZ;
      4'b11_00: return KEY_SUBMIT_LETTER;
      4'b11_01: return KEY_CLEAR;
      4'b11_10: return KEY_SUBMIT_WORD;
      default:  return KEY_NONE;
    endcase
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: counts consecutive cycles with match high; done pulses on
// the N-th consecutive matching sample. Any mismatch or clear restarts the count.
// Ports:
//   clk, nRst : clock, async active-low reset
//   clear     : hold the counter at zero (owner FSM not in the watching state)
//   match     : current sample agrees with the reference
//   done      : N consecutive matching samples seen (combinational)
module keypad_debounce #(
  parameter int unsigned N = 20
) (
  input  logic clk,
  input  logic nRst,
  input  logic clear,
  input  logic match,
  output logic done
);

  localparam int unsigned CW = $clog2(N + 1);

  logic [CW-1:0] count;

  assign done = match && !clear && (count == CW'(N - 1));

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      count <= '0;
    end else if (clear || !match || done) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_multitap_encoder.sv
// keypad_multitap_encoder: scans a 4x4 matrix keypad, debounces presses and
// releases, and turns repeated taps of one key into a single ASCII letter.
// Ports:
//   clk            : 1 kHz system clock
//   nRst           : async active-low reset
//   rows[3:0]      : row sense lines for the strobed column
//   cols[3:0]      : one-hot column strobe
//   pending_letter : letter currently being tapped (0 when none)
//   pending_valid  : pending_letter is meaningful
//   letter         : last committed letter, held until the next commit
//   letter_valid   : 1-cycle strobe on commit
//   word_submit    : 1-cycle strobe on the submit-word key
//   key_error      : 1-cycle strobe on an illegal action
// Optional: define KEYPAD_AUTOCOMMIT_EN to commit the pending letter
// automatically when the tap timer runs out.
//
// state       | meaning
// ST_SCAN     | rotating column strobe, looking for a single closed row
// ST_DEBOUNCE | column frozen, counting identical row samples
// ST_PRESSED  | one cycle: decode key and apply its action
// ST_HOLD     | column frozen, waiting for a debounced release
module keypad_multitap_encoder
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_TICKS      = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned TAP_TIMEOUT     = 1000
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [7:0] pending_letter,
  output logic       pending_valid,
  output logic [7:0] letter,
  output logic       letter_valid,
  output logic       word_submit,
  output logic       key_error
);

  localparam int unsigned SW = $clog2(SCAN_TICKS + 1);
  localparam int unsigned TW = $clog2(TAP_TIMEOUT + 1);

  state_t        state, state_next;
  logic [SW-1:0] scan_cnt;
  logic [3:0]    row_latch;
  logic [TW-1:0] tap_timer;
  key_code_t     pending_key;
  logic [1:0]    tap_idx;
  logic          press_done, release_done;
  logic          row_single;
  key_code_t     key;
  logic [2:0]    idx_inc;

  // Chords (several rows on one column) are never accepted as a press.
  assign row_single = (rows != 4'b0) && ((rows & (rows - 4'd1)) == 4'b0);
  assign key        = decode_key(onehot_idx(row_latch), onehot_idx(cols));
  assign idx_inc    = {1'b0, tap_idx} + 3'd1;

  assign pending_letter = pending_valid ? (group_base(pending_key) + {6'b0, tap_idx}) : 8'h00;

  keypad_debounce #(.N(DEBOUNCE_CYCLES)) u_press_db (
    .clk   (clk),
    .nRst  (nRst),
    .clear (state != ST_DEBOUNCE),
    .match (rows == row_latch),
    .done  (press_done)
  );

  keypad_debounce #(.N(DEBOUNCE_CYCLES)) u_release_db (
    .clk   (clk),
    .nRst  (nRst),
    .clear (state != ST_HOLD),
    .match (rows == 4'b0),
    .done  (release_done)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= ST_SCAN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_SCAN:     if (row_single) state_next = ST_DEBOUNCE;
      ST_DEBOUNCE: begin
        if (rows != row_latch) state_next = ST_SCAN;
        else if (press_done)   state_next = ST_PRESSED;
      end
      ST_PRESSED:  state_next = ST_HOLD;
      ST_HOLD:     if (release_done) state_next = ST_SCAN;
      default:     state_next = ST_SCAN;
    endcase
  end

  // Column strobe and row latch. Columns only move while scanning with no
  // single-row hit, so a candidate press keeps its column until released.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cols      <= 4'b0001;
      scan_cnt  <= '0;
      row_latch <= 4'b0;
    end else if (state == ST_SCAN && !row_single) begin
      if (scan_cnt == SW'(SCAN_TICKS - 1)) begin
        scan_cnt <= '0;
        cols     <= {cols[2:0], cols[3]};
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end else begin
      scan_cnt <= '0;
      if (state == ST_SCAN) row_latch <= rows;
    end
  end

  // Key actions and the tap timer.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      tap_timer     <= '0;
      pending_key   <= KEY_NONE;
      tap_idx       <= '0;
      pending_valid <= 1'b0;
      letter        <= 8'h00;
      letter_valid  <= 1'b0;
      word_submit   <= 1'b0;
      key_error     <= 1'b0;
    end else begin
      letter_valid <= 1'b0;
      word_submit  <= 1'b0;
      key_error    <= 1'b0;
      if (tap_timer != TW'(TAP_TIMEOUT)) tap_timer <= tap_timer + 1'b1;

      if (state == ST_PRESSED) begin
        if (is_letter(key)) begin
          if (pending_valid && key == pending_key && tap_timer < TW'(TAP_TIMEOUT)) begin
            tap_idx <= (idx_inc == group_size(key)) ? 2'd0 : idx_inc[1:0];
          end else begin
            pending_key   <= key;
            tap_idx       <= 2'd0;
            pending_valid <= 1'b1;
          end
          tap_timer <= '0;
        end else begin
          case (key)
            KEY_SUBMIT_LETTER: begin
              if (pending_valid) begin
                letter        <= pending_letter;
                letter_valid  <= 1'b1;
                pending_valid <= 1'b0;
              end else begin
                key_error <= 1'b1;
              end
            end
            KEY_CLEAR:       pending_valid <= 1'b0;
            KEY_SUBMIT_WORD: word_submit   <= 1'b1;
            default:         key_error     <= 1'b1;
          endcase
        end
      end
`ifdef KEYPAD_AUTOCOMMIT_EN
      else if (pending_valid && tap_timer == TW'(TAP_TIMEOUT)) begin
        letter        <= pending_letter;
        letter_valid  <= 1'b1;
        pending_valid <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_keypad_multitap_encoder.sv
// tb_keypad_multitap_encoder: directed and random keypad stimulus checked
// against a behavioural multi-tap model (taps, groups, timeouts as plain integers).
module tb_keypad_multitap_encoder;

  localparam int SCAN_TICKS = 2;
  localparam int DEB        = 20;
  localparam int TIMEOUT    = 1000;

  logic       clk = 1'b0;
  logic       nRst;
  logic [3:0] rows, cols;
  logic [7:0] pending_letter, letter;
  logic       pending_valid, letter_valid, word_submit, key_error;

  keypad_multitap_encoder #(
    .SCAN_TICKS(SCAN_TICKS), .DEBOUNCE_CYCLES(DEB), .TAP_TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .nRst(nRst), .rows(rows), .cols(cols),
    .pending_letter(pending_letter), .pending_valid(pending_valid),
    .letter(letter), .letter_valid(letter_valid),
    .word_submit(word_submit), .key_error(key_error)
  );

  always #5 clk = ~clk;

  // Physical keypad: a held key closes its row only while its column is strobed.
  logic       key_down = 1'b0;
  int         key_r = 0, key_c = 0;
  logic       force_en = 1'b0;
  logic [3:0] force_val = 4'b0;

  always_comb begin
    rows = 4'b0;
    if (force_en) rows = force_val;
    else if (key_down && cols[key_c]) rows = 4'(1 << key_r);
  end

  int cyc = 0, lv_cnt = 0, ws_cnt = 0, err_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (letter_valid) lv_cnt <= lv_cnt + 1;
    if (word_submit)  ws_cnt <= ws_cnt + 1;
    if (key_error)    err_cnt <= err_cnt + 1;
  end

  // Reference model. Codes: 0..7 letter groups, 8 submit letter, 9 clear,
  // 10 submit word, -1 no function.
  int keymap [4][4] = '{'{-1, 0, 1, -1}, '{2, 3, 4, -1}, '{5, 6, 7, -1}, '{8, 9, 10, -1}};
  int gsize [8] = '{3, 3, 3, 3, 3, 4, 3, 4};
  int m_valid = 0, m_group = 0, m_idx = 0, m_last_tap = -100000, m_letter = 0;
  int exp_lv = 0, exp_ws = 0, exp_err = 0;
  int n_checks = 0, n_err = 0;

  function automatic int gbase(int g);
    int b = 65;
    for (int i = 0; i < g; i++) b += gsize[i];
    return b;
  endfunction

  function automatic int m_pending();
    return (m_valid != 0) ? gbase(m_group) + m_idx : 0;
  endfunction

  task automatic chk(string tag, int obs, int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_press(int code, int t);
`ifdef KEYPAD_AUTOCOMMIT_EN
    if (m_valid != 0 && t - m_last_tap >= TIMEOUT) begin
      m_letter = m_pending();
      exp_lv++;
      m_valid = 0;
    end
`endif
    if (code >= 0 && code < 8) begin
      if (m_valid != 0 && m_group == code && t - m_last_tap < TIMEOUT)
        m_idx = (m_idx + 1) % gsize[code];
      else begin
        m_group = code; m_idx = 0; m_valid = 1;
      end
      m_last_tap = t;
    end else if (code == 8) begin
      if (m_valid != 0) begin
        m_letter = m_pending(); exp_lv++; m_valid = 0;
      end else exp_err++;
    end else if (code == 9) m_valid = 0;
    else if (code == 10) exp_ws++;
    else exp_err++;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  // Keeps press times clear of the tap-timeout boundary so scan jitter
  // cannot change the expected outcome.
  task automatic avoid_boundary();
    int e;
    e = cyc - m_last_tap;
    if (m_valid != 0 && e > TIMEOUT - 160 && e < TIMEOUT + 60) idle(230);
  endtask

  task automatic press(int r, int c, int hold);
    avoid_boundary();
    model_press(keymap[r][c], cyc);
    key_r = r; key_c = c; key_down = 1'b1;
    idle(hold);
    key_down = 1'b0;
    idle(40);
  endtask

  task automatic check_all(string tag);
    chk({tag, ".pvalid"}, int'(pending_valid), int'(m_valid != 0));
    chk({tag, ".pletter"}, int'(pending_letter), m_pending());
    chk({tag, ".letter"}, int'(letter), m_letter);
    chk({tag, ".lv_cnt"}, lv_cnt, exp_lv);
    chk({tag, ".ws_cnt"}, ws_cnt, exp_ws);
    chk({tag, ".err_cnt"}, err_cnt, exp_err);
  endtask

  task automatic check_rotation(string tag);
    logic [3:0] c0;
    c0 = cols;
    chk({tag, ".onehot"}, $countones(c0), 1);
    idle(SCAN_TICKS);
    chk({tag, ".rotate"}, int'(cols), int'((c0 << 1 | c0 >> 3) & 4'hF));
  endtask

  initial begin
    nRst = 1'b0;
    idle(3);
    chk("rst.cols", int'(cols), 1);
    chk("rst.pletter", int'(pending_letter), 0);
    chk("rst.pvalid", int'(pending_valid), 0);
    chk("rst.letter", int'(letter), 0);
    chk("rst.strobes", int'({letter_valid, word_submit, key_error}), 0);
    nRst = 1'b1;
    idle(5);

    // A then submit
    press(0, 1, 50);
    check_all("abc");
    chk("tp.A", int'(pending_letter), 8'h41);
    press(3, 0, 45);
    check_all("submitA");
    chk("tp.letterA", int'(letter), 8'h41);

    // PQRS taps 200 cycles apart, submit S, then five taps wrap to P
    for (int i = 0; i < 4; i++) begin
      press(2, 0, 45);
      check_all("pqrs");
      idle(115);
    end
    chk("tp.S", int'(pending_letter), 8'h53);
    press(3, 0, 45);
    check_all("submitS");
    chk("tp.letterS", int'(letter), 8'h53);
    for (int i = 0; i < 5; i++) begin
      press(2, 0, 45);
      idle(115);
    end
    check_all("wrap");
    chk("tp.wrapP", int'(pending_letter), 8'h50);
    press(3, 1, 45);
    check_all("clear");

    // Tap timeout: second J starts a new sequence
    press(1, 1, 45);
    idle(1200);
    press(1, 1, 45);
    check_all("timeout");
    chk("tp.J", int'(pending_letter), 8'h4A);
    press(3, 0, 45);
    check_all("submitJ");

    // Short glitch and a chord produce nothing; scanning resumes
    force_val = 4'b0100; force_en = 1'b1;
    idle(10);
    force_en = 1'b0;
    idle(30);
    check_rotation("glitch");
    check_all("glitch");
    force_val = 4'b0011; force_en = 1'b1;
    idle(50);
    check_rotation("chord");
    force_en = 1'b0;
    idle(30);
    check_all("chord");

    // Error and word-submit cases
    press(3, 0, 45);
    check_all("empty_submit");
    press(3, 2, 45);
    check_all("word");
    press(0, 0, 45);
    check_all("unmapped");
    press(0, 3, 45);
    check_all("unmapped2");

    // Reset while holding the second DEF tap
    press(0, 2, 45);
    avoid_boundary();
    model_press(1, cyc);
    key_r = 0; key_c = 2; key_down = 1'b1;
    idle(60);
    chk("hold.E", int'(pending_letter), 8'h45);
    #2 nRst = 1'b0;
    #1;
    chk("mid.cols", int'(cols), 1);
    chk("mid.pletter", int'(pending_letter), 0);
    chk("mid.pvalid", int'(pending_valid), 0);
    chk("mid.letter", int'(letter), 0);
    chk("mid.strobes", int'({letter_valid, word_submit, key_error}), 0);
    m_valid = 0; m_letter = 0;
    idle(3);
    nRst = 1'b1;
    model_press(1, cyc);
    idle(60);
    key_down = 1'b0;
    idle(40);
    check_all("rehold");
    chk("tp.D", int'(pending_letter), 8'h44);

    // Random keys and gaps
    for (int i = 0; i < 30; i++) begin
      int r, c;
      if ($urandom_range(0, 3) != 0) begin
        r = $urandom_range(0, 2);
        c = (r == 0) ? $urandom_range(1, 2) : $urandom_range(0, 2);
      end else begin
        r = $urandom_range(0, 3);
        c = $urandom_range(0, 3);
      end
      press(r, c, $urandom_range(40, 60));
      check_all("rand");
      if ($urandom_range(0, 5) == 0) idle($urandom_range(1100, 1300));
      else idle($urandom_range(0, 300));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
